// File: rtl/fifo_sync_ram_ctrl.sv
// fifo_sync_ram_ctrl: single-clock FIFO controller driving an external synchronous RAM
module fifo_sync_ram_ctrl #(
    parameter int WIDTH         = 32,
    parameter int DEPTH_LOG2    = 7,
    parameter int RD_LATENCY    = 1,
    parameter int AFULL_THRESH  = 120,
    parameter int AEMPTY_THRESH = 8
) (
    input  logic                  CLOCK,
    input  logic                  RESET,
    input  logic                  WE,
    input  logic [WIDTH-1:0]      DATA,
    input  logic                  RE,
    output logic [WIDTH-1:0]      Q,
    output logic                  DVLD,
    output logic                  FULL,
    output logic                  AFULL,
    output logic                  EMPTY,
    output logic                  AEMPTY,
    output logic                  OVERFLOW,
    output logic                  UNDERFLOW,
    output logic [DEPTH_LOG2:0]   WRCNT,
    output logic [DEPTH_LOG2-1:0] RAM_WADDR,
    output logic                  RAM_WEN,
    output logic [WIDTH-1:0]      RAM_WDATA,
    output logic [DEPTH_LOG2-1:0] RAM_RADDR,
    output logic                  RAM_REN,
    input  logic [WIDTH-1:0]      RAM_RDATA
);
    localparam logic [DEPTH_LOG2:0] AF = (DEPTH_LOG2+1)'(AFULL_THRESH);
    localparam logic [DEPTH_LOG2:0] AE = (DEPTH_LOG2+1)'(AEMPTY_THRESH);

    logic [DEPTH_LOG2:0] wptr, rptr, wptr_next, rptr_next, cnt_next;
    logic                wr_ok, rd_ok;
    logic [RD_LATENCY-1:0] vld_sr;
    logic [RD_LATENCY:0]   vld_in;

    // Accept decisions use only registered flags, so no request-to-flag combinational path exists.
    assign wr_ok     = WE & ~FULL;
    assign rd_ok     = RE & ~EMPTY;
    assign RAM_WEN   = wr_ok;
    assign RAM_WDATA = DATA;
    assign RAM_REN   = rd_ok;
    assign RAM_WADDR = wptr[DEPTH_LOG2-1:0];
    assign RAM_RADDR = rptr[DEPTH_LOG2-1:0];
    assign wptr_next = wptr + (DEPTH_LOG2+1)'(wr_ok);
    assign rptr_next = rptr + (DEPTH_LOG2+1)'(rd_ok);
    // Pointer difference with wrap bit equals WRCNT + wr_ok - rd_ok.
    assign cnt_next  = wptr_next - rptr_next;
    assign vld_in    = {vld_sr, rd_ok};
    assign DVLD      = vld_sr[RD_LATENCY-1];
    assign Q         = RAM_RDATA;

    // Pointers, occupancy, registered flags, error pulses and read-valid pipeline.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            wptr      <= '0;
            rptr      <= '0;
            WRCNT     <= '0;
            FULL      <= 1'b0;
            AFULL     <= 1'b0;
            EMPTY     <= 1'b1;
            AEMPTY    <= 1'b1;
            OVERFLOW  <= 1'b0;
            UNDERFLOW <= 1'b0;
            vld_sr    <= '0;
        end else begin
            wptr      <= wptr_next;
            rptr      <= rptr_next;
            WRCNT     <= cnt_next;
            FULL      <= cnt_next[DEPTH_LOG2];
            AFULL     <= cnt_next >= AF;
            EMPTY     <= cnt_next == '0;
            AEMPTY    <= cnt_next <= AE;
            OVERFLOW  <= WE & FULL;
            UNDERFLOW <= RE & EMPTY;
            vld_sr    <= vld_in[RD_LATENCY-1:0];
        end
    end
endmodule

// File: doc/fifo_sync_ram_ctrl.md
# fifo_sync_ram_ctrl

Single-clock FIFO controller that drives the write and read ports of the COREFIFO LSRAM wrapper: it generates write/read addresses and enables, maintains occupancy, and produces full/empty/threshold flags. It is the user-facing front end of the digitizer's synchronous sample FIFOs. The RAM is instantiated outside this block and connected through the RAM_* ports.

## Interface
- WIDTH, 32: data width in bits; RAM width must match.
- DEPTH_LOG2, 7: log2 of FIFO depth; depth = 2^DEPTH_LOG2 words.
- RD_LATENCY, 1: RAM read latency in cycles from RAM_REN to valid RAM_RDATA; legal values 1 or 2.
- AFULL_THRESH, 120: AFULL asserted when occupancy >= this value.
- AEMPTY_THRESH, 8: AEMPTY asserted when occupancy <= this value.

Ports:
- CLOCK  in  1  single clock for all logic.
- RESET  in  1  asynchronous, active-high reset.
- WE  in  1  write request.
- DATA  in  WIDTH  write data.
- RE  in  1  read request.
- Q  out  WIDTH  read data, equal to RAM_RDATA, qualified by DVLD.
- DVLD  out  1  Q valid strobe.
- FULL, AFULL, EMPTY, AEMPTY  out  1 each  status flags.
- OVERFLOW  out  1  write rejected this cycle because FULL.
- UNDERFLOW  out  1  read rejected this cycle because EMPTY.
- WRCNT  out  DEPTH_LOG2+1  current occupancy.
- RAM_WADDR  out  DEPTH_LOG2  RAM write address.
- RAM_WEN  out  1  RAM write enable.
- RAM_WDATA  out  WIDTH  RAM write data.
- RAM_RADDR  out  DEPTH_LOG2  RAM read address.
- RAM_REN  out  1  RAM read enable.
- RAM_RDATA  in  WIDTH  RAM read data.

## Operation
- Pointers: wptr, rptr, each DEPTH_LOG2+1 bits with wrap bit. RAM_WADDR and RAM_RADDR are the low DEPTH_LOG2 bits of the respective pointer.
- Write accept: wr_ok = WE & ~FULL. RAM_WEN = wr_ok, RAM_WDATA = DATA, both combinational. wptr increments on wr_ok and wraps modulo 2^(DEPTH_LOG2+1).
- Read accept: rd_ok = RE & ~EMPTY. RAM_REN = rd_ok, combinational. rptr increments on rd_ok.
- FULL and EMPTY are registered, so accept decisions use the previous cycle's flags.
  - Simultaneous WE & RE while FULL: the read is accepted; the write is rejected with OVERFLOW = 1.
  - Simultaneous WE & RE while EMPTY: the write is accepted; the read is rejected with UNDERFLOW = 1.
- Occupancy: WRCNT_next = WRCNT + wr_ok - rd_ok. Accepted write and read in the same cycle leave WRCNT unchanged.
- Flags are registered from WRCNT_next:
  - FULL = (WRCNT_next == 2^DEPTH_LOG2)
  - EMPTY = (WRCNT_next == 0)
  - AFULL = (WRCNT_next >= AFULL_THRESH)
  - AEMPTY = (WRCNT_next <= AEMPTY_THRESH)
- OVERFLOW and UNDERFLOW are registered single-cycle pulses, asserted the cycle after the rejected request.
- DVLD: rd_ok is delayed through a RD_LATENCY-stage shift register. Q = RAM_RDATA unmodified.
- Reset values while RESET is asserted: wptr = rptr = 0, WRCNT = 0, EMPTY = 1, AEMPTY = 1, FULL = 0, AFULL = 0, OVERFLOW = UNDERFLOW = 0, DVLD pipeline cleared.
- Reset asserted mid-read discards in-flight reads: no DVLD is produced after reset.

## Timing
- Write to visible: a write accepted at edge N makes EMPTY deassert after edge N.
- Read latency: RE accepted at edge N gives DVLD = 1 and valid Q after edge N+RD_LATENCY−1+1, i.e. RD_LATENCY cycles later.
- Back-to-back reads sustain one word per cycle. Writes likewise.
- No combinational path from RE/WE to any flag output. RAM_WEN and RAM_REN depend combinationally on WE/RE and registered flags only.

## Test plan
- Fill/drain (DEPTH_LOG2=3, thresholds 6/2):
  - Write 0x01..0x08 → FULL = 1 after 8th edge, WRCNT = 8, AFULL = 1 from 6th.
  - Then read 8 → Q = 0x01..0x08 with DVLD, EMPTY = 1, AEMPTY = 1 from WRCNT <= 2.
- Overflow: when full, WE = 1 for 1 cycle with DATA = 0xDEAD → RAM_WEN = 0, OVERFLOW pulse of 1 cycle, WRCNT stays 8, 0xDEAD never read.
- Underflow and simultaneous-on-empty: when empty, WE = RE = 1 with DATA = 0x55 → write accepted, UNDERFLOW = 1, WRCNT = 1; next RE returns 0x55.
- Wrap-around: 20 write/read pairs at steady occupancy 3 → addresses wrap through 7 → 0, data order preserved, WRCNT constant 3, no flag glitches.
- RD_LATENCY = 2: single read → DVLD exactly 2 cycles after RAM_REN.
- Reset mid-operation: assert RESET one cycle after RE accepted → no DVLD afterward, EMPTY = 1, WRCNT = 0, RAM_WADDR = RAM_RADDR = 0.
